adc_echo_buffer: RTL and testbench
==================================

// Module: adc_echo_buffer
// PURPOSE
//  Downstream consumer of the ADC acquisition window generator's ACQ_EN. Captures one ADC sample per CLK while
//  ACQ_EN is high and tags each sample with an echo index and a LAST flag (final sample of the echo).
//  Buffers the tagged words in an internal FIFO and presents them on a valid/ready stream to the readout/DMA stage.
//  Reports fill level, sticky overflow, echo count and last-echo length for the control block.
// PARAMETERS
//  ADC_WIDTH          12  ADC sample width
//  ECHO_CNT_WIDTH     16  echo index / echo counter width (wraps)
//  SAMPLE_CNT_WIDTH   16  per-echo sample counter width (saturates)
//  FIFO_DEPTH_LOG2     8  FIFO depth = 2**FIFO_DEPTH_LOG2 words
// PORTS
//  CLK            in   1                       system/ADC clock, rising edge
//  RESET_N        in   1                       asynchronous, active-low reset
//  CLR            in   1                       synchronous clear: FIFO, counters, OVERFLOW
//  ACQ_EN         in   1                       sample strobe from window generator, contiguous run per echo
//  ADC_DATA       in   ADC_WIDTH               sample, valid in every cycle with ACQ_EN=1
//  OUT_DATA       out  1+ECHO_CNT_WIDTH+ADC_WIDTH  {LAST, ECHO_IDX, SAMPLE}
//  OUT_VALID      out  1                       OUT_DATA holds a word
//  OUT_READY      in   1                       consumer accepts word when OUT_VALID&OUT_READY
//  FIFO_LEVEL     out  FIFO_DEPTH_LOG2+1       words stored, including the word on OUT_DATA
//  OVERFLOW       out  1                       sticky: at least one word dropped since reset/CLR
//  ECHO_COUNT     out  ECHO_CNT_WIDTH          completed echoes (equals next ECHO_IDX)
//  LAST_ECHO_LEN  out  SAMPLE_CNT_WIDTH        samples captured in the most recent completed echo
// BEHAVIOUR
//  - Reset (RESET_N=0, async): all outputs 0, FIFO empty, FSM=IDLE, stage register cleared.
//  - FSM: IDLE, CAPTURE, DISCARD.
//    IDLE:    ACQ_EN=1 -> load stage reg with ADC_DATA, sample_cnt=1, go to CAPTURE.
//    CAPTURE: ACQ_EN=1 -> write stage (LAST=0), reload stage, sample_cnt+1 (saturating).
//             ACQ_EN=0 -> write stage (LAST=1), LAST_ECHO_LEN<=sample_cnt, ECHO_COUNT+1 (wraps), go to IDLE.
//    DISCARD: ignores samples. ACQ_EN=0 -> go to IDLE.
//  - Latency: sample taken at edge n is written to the FIFO at edge n+1. OUT_VALID is high after edge n+2 if the
//    FIFO was empty (first-word fall-through, registered output).
//  - A single-cycle ACQ_EN pulse produces one word with LAST=1. Echo length 1 is legal.
//  - ECHO_IDX field = ECHO_COUNT value at echo start. All words of one echo carry the same index.
//  - FIFO full at a write edge: word dropped, OVERFLOW<=1. The full test uses the pre-read level, so a
//    simultaneous read does not rescue the write.
//  - A dropped LAST word still updates ECHO_COUNT and LAST_ECHO_LEN.
//  - Read on empty: no effect. Simultaneous read and write on non-full: FIFO_LEVEL unchanged.
//  - CLR (any state, priority over all other actions): FIFO emptied, OUT_VALID=0, OVERFLOW=0, ECHO_COUNT=0,
//    LAST_ECHO_LEN=0, stage dropped. Next state is DISCARD if ACQ_EN=1, else IDLE. No partial echo is ever emitted.
//  - After reset release with ACQ_EN already high: enter DISCARD, not CAPTURE.
// STRUCTURE
//  - Shared package adc_acq_pkg: FSM state encoding (IDLE/CAPTURE/DISCARD), OUT_DATA field offsets
//    (LAST_BIT, ECHO_LSB, SAMPLE_LSB), default widths.
//  - One sub-module: sync_fifo_fwft (single clock, async active-low reset, sync clear, level output,
//    write-when-full ignored).
//  - Top level holds the FSM, stage register, counters and OVERFLOW flag.
// TESTING
//  1. ACQ_EN high 10 cycles, ADC_DATA=0..9, OUT_READY=1 -> 10 words, samples 0..9, ECHO_IDX=0, LAST only on 9;
//     ECHO_COUNT=1, LAST_ECHO_LEN=10.
//  2. Two 10-cycle echoes separated by 10 idle cycles -> second echo ECHO_IDX=1, ECHO_COUNT=2.
//  3. One-cycle ACQ_EN pulse -> single word with LAST=1, LAST_ECHO_LEN=1.
//  4. FIFO_DEPTH_LOG2=3, OUT_READY=0, 12-sample echo -> FIFO_LEVEL=8, OVERFLOW=1, words 0..7 retained.
//     ECHO_COUNT=1 (echo counted although its LAST word was dropped).
//  5. CLR pulse at sample 4 of a 10-sample echo -> FIFO empty, DISCARD until ACQ_EN falls, no words from that echo.
//     Next echo ECHO_IDX=0.
//  6. RESET_N low mid-echo, released while ACQ_EN high -> outputs 0, no words until the next full echo.
//     Random OUT_READY backpressure over 3 echoes -> word order and tags preserved.

Source files
------------

// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition path: FSM encoding, default widths
// and the bit layout of the tagged output word {LAST, ECHO_IDX, SAMPLE}.
package adc_acq_pkg;

  localparam int ADC_WIDTH_DEF        = 12;
  localparam int ECHO_CNT_WIDTH_DEF   = 16;
  localparam int SAMPLE_CNT_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_LOG2_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DISCARD = 2'd2
  } acq_state_e;

  // Word layout: sample in the low bits, echo index above it, LAST on top.
  localparam int SAMPLE_LSB = 0;

  function automatic int echo_lsb(input int adc_w);
    return SAMPLE_LSB + adc_w;
  endfunction

  function automatic int last_bit(input int adc_w, input int echo_w);
    return SAMPLE_LSB + adc_w + echo_w;
  endfunction

  function automatic int word_width(input int adc_w, input int echo_w);
    return 1 + adc_w + echo_w;
  endfunction

endpackage

// File: rtl/adc_echo_buffer_if.sv
// Valid/ready stream carrying tagged ADC words to the readout/DMA stage.
interface adc_echo_buffer_if
  import adc_acq_pkg::*;
#(
  parameter int DATA_W = word_width(ADC_WIDTH_DEF, ECHO_CNT_WIDTH_DEF)
);
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;

  modport master (output OUT_DATA, output OUT_VALID, input OUT_READY);
  modport slave  (input  OUT_DATA, input  OUT_VALID, output OUT_READY);
endinterface

// File: rtl/adc_echo_buffer_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered output word.
// Level counts the output register too; writes while full are dropped.
module sync_fifo_fwft
  import adc_acq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  full_o
);
  localparam int                  DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q, level_d, mem_cnt;
  logic [WIDTH-1:0]      dout_q;
  logic                  vld_q;
  logic                  wr_acc, rd_acc, pop;

  // Full is judged on the pre-read level: a same-cycle read never frees room.
  assign full_o  = (level_q == LVL_FULL);
  assign wr_acc  = wr_en_i & ~full_o & ~clr_i;
  assign rd_acc  = rd_en_i & vld_q;
  assign mem_cnt = level_q - (DEPTH_LOG2+1)'(vld_q);
  assign pop     = (mem_cnt != '0) & (~vld_q | rd_acc);
  assign level_d = level_q + (DEPTH_LOG2+1)'(wr_acc) - (DEPTH_LOG2+1)'(rd_acc);

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      vld_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        dout_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
        vld_q    <= 1'b1;
      end else if (rd_acc) begin
        vld_q    <= 1'b0;
      end
    end
  end

  assign rd_data_o  = dout_q;
  assign rd_valid_o = vld_q;
  assign level_o    = level_q;

endmodule

// File: rtl/adc_echo_buffer.sv
// Captures ADC samples while ACQ_EN is high, tags them with echo index and LAST,
// and buffers them for the readout stream. Tracks echo count, length and overflow.
module adc_echo_buffer
  import adc_acq_pkg::*;
#(
  parameter int ADC_WIDTH        = ADC_WIDTH_DEF,
  parameter int ECHO_CNT_WIDTH   = ECHO_CNT_WIDTH_DEF,
  parameter int SAMPLE_CNT_WIDTH = SAMPLE_CNT_WIDTH_DEF,
  parameter int FIFO_DEPTH_LOG2  = FIFO_DEPTH_LOG2_DEF
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        CLR,
  input  logic                        ACQ_EN,
  input  logic [ADC_WIDTH-1:0]        ADC_DATA,
  adc_echo_buffer_if.master           out_if,
  output logic [FIFO_DEPTH_LOG2:0]    FIFO_LEVEL,
  output logic                        OVERFLOW,
  output logic [ECHO_CNT_WIDTH-1:0]   ECHO_COUNT,
  output logic [SAMPLE_CNT_WIDTH-1:0] LAST_ECHO_LEN
);
  localparam int WORD_W   = word_width(ADC_WIDTH, ECHO_CNT_WIDTH);
  localparam int ECHO_LSB = echo_lsb(ADC_WIDTH);
  localparam int LAST_BIT = last_bit(ADC_WIDTH, ECHO_CNT_WIDTH);

  acq_state_e                  state_q, state_d;
  logic [ADC_WIDTH-1:0]        stage_q, stage_d;
  logic [SAMPLE_CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
  logic [ECHO_CNT_WIDTH-1:0]   echo_cnt_q, echo_cnt_d;
  logic [SAMPLE_CNT_WIDTH-1:0] last_len_q, last_len_d;
  logic                        ovf_q, ovf_d;
  logic                        armed_q, armed_d;
  logic                        wr_en, wr_last, fifo_full;
  logic [WORD_W-1:0]           wr_word;

  // An echo may only start once ACQ_EN has been seen low since reset; this
  // keeps a run already in progress at reset release out of the buffer.
  assign armed_d = armed_q | ~ACQ_EN;

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    sample_cnt_d = sample_cnt_q;
    echo_cnt_d   = echo_cnt_q;
    last_len_d   = last_len_q;
    ovf_d        = ovf_q;
    wr_en        = 1'b0;
    wr_last      = 1'b0;
    if (CLR) begin
      state_d      = ACQ_EN ? ST_DISCARD : ST_IDLE;
      sample_cnt_d = '0;
      echo_cnt_d   = '0;
      last_len_d   = '0;
      ovf_d        = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ACQ_EN && armed_q) begin
            stage_d      = ADC_DATA;
            sample_cnt_d = SAMPLE_CNT_WIDTH'(1);
            state_d      = ST_CAPTURE;
          end else if (ACQ_EN) begin
            state_d = ST_DISCARD;
          end
        end
        ST_CAPTURE: begin
          wr_en = 1'b1;
          if (ACQ_EN) begin
            stage_d = ADC_DATA;
            if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + 1'b1;
          end else begin
            wr_last    = 1'b1;
            last_len_d = sample_cnt_q;
            echo_cnt_d = echo_cnt_q + 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (!ACQ_EN) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      // A dropped word still counts toward the echo statistics above.
      if (wr_en && fifo_full) ovf_d = 1'b1;
    end
  end

  always_comb begin
    wr_word                                  = '0;
    wr_word[LAST_BIT]                        = wr_last;
    wr_word[ECHO_LSB +: ECHO_CNT_WIDTH]      = echo_cnt_q;
    wr_word[SAMPLE_LSB +: ADC_WIDTH]         = stage_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      stage_q      <= '0;
      sample_cnt_q <= '0;
      echo_cnt_q   <= '0;
      last_len_q   <= '0;
      ovf_q        <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      sample_cnt_q <= sample_cnt_d;
      echo_cnt_q   <= echo_cnt_d;
      last_len_q   <= last_len_d;
      ovf_q        <= ovf_d;
      armed_q      <= armed_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH      (WORD_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .clr_i      (CLR),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_word),
    .rd_en_i    (out_if.OUT_READY),
    .rd_data_o  (out_if.OUT_DATA),
    .rd_valid_o (out_if.OUT_VALID),
    .level_o    (FIFO_LEVEL),
    .full_o     (fifo_full)
  );

  assign OVERFLOW      = ovf_q;
  assign ECHO_COUNT    = echo_cnt_q;
  assign LAST_ECHO_LEN = last_len_q;

endmodule

// File: tb/tb_adc_echo_buffer.sv
// Self-checking bench for adc_echo_buffer: echo table, latency/overflow/CLR/reset
// sequences, and randomized backpressure against a word-list reference model.
module tb_adc_echo_buffer;
  localparam int AW = 12;
  localparam int EW = 16;
  localparam int SW = 16;
  localparam int DL = 3;
  localparam int WW = 1 + EW + AW;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          CLR = 1'b0;
  logic          ACQ_EN = 1'b0;
  logic [AW-1:0] ADC_DATA = '0;
  logic [DL:0]   FIFO_LEVEL;
  logic          OVERFLOW;
  logic [EW-1:0] ECHO_COUNT;
  logic [SW-1:0] LAST_ECHO_LEN;

  adc_echo_buffer_if #(.DATA_W(WW)) bus();

  adc_echo_buffer #(
    .ADC_WIDTH(AW), .ECHO_CNT_WIDTH(EW), .SAMPLE_CNT_WIDTH(SW), .FIFO_DEPTH_LOG2(DL)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLR(CLR), .ACQ_EN(ACQ_EN), .ADC_DATA(ADC_DATA),
    .out_if(bus), .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW),
    .ECHO_COUNT(ECHO_COUNT), .LAST_ECHO_LEN(LAST_ECHO_LEN)
  );

  always #5 CLK = ~CLK;

  int            n_cmp = 0;
  int            n_fail = 0;
  bit            rand_rdy = 1'b0;
  int            mdl_echo = 0;
  int            mdl_len = 0;
  int            rx_rd = 0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] rx_q[$];

  typedef struct {
    int            len;
    int            gap;
    logic [EW-1:0] exp_cnt;
    logic [SW-1:0] exp_len;
  } vec_t;
  vec_t tbl[4];

  // Transfers complete at the next rising edge when valid&ready are seen here.
  always @(negedge CLK)
    if (RESET_N && bus.OUT_VALID && bus.OUT_READY) rx_q.push_back(bus.OUT_DATA);

  function automatic logic [WW-1:0] mk(input logic l, input logic [EW-1:0] idx, input logic [AW-1:0] s);
    return {l, idx, s};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_rdy) bus.OUT_READY = 1'($urandom_range(0, 1));
  endtask

  // Drives one echo; the model expects one word per sample, LAST on the final
  // one, tagged with the number of echoes completed so far.
  task automatic echo(input int len, input int keep, input bit rnd, input logic [AW-1:0] base);
    for (int i = 0; i < len; i++) begin
      logic [AW-1:0] s;
      s = rnd ? AW'($urandom_range(0, 4095)) : base + AW'(i);
      ACQ_EN = 1'b1;
      ADC_DATA = s;
      if (i < keep) exp_q.push_back(mk(i == len - 1, EW'(mdl_echo), s));
      tick();
    end
    ACQ_EN = 1'b0;
    tick();
    mdl_echo++;
    mdl_len = len;
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((FIFO_LEVEL != 0 || bus.OUT_VALID) && k < 500) begin
      tick();
      k++;
    end
    if (k >= 500) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: level %0d required 0", nm, FIFO_LEVEL);
    end
    tick();
    chk({nm, "_nwords"}, 64'(rx_q.size() - rx_rd), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && rx_rd + i < rx_q.size(); i++)
      chk({nm, "_word"}, 64'(rx_q[rx_rd + i]), 64'(exp_q[i]));
    rx_rd = rx_q.size();
    exp_q.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_level"}, 64'(FIFO_LEVEL), 0);
    chk({nm, "_valid"}, 64'(bus.OUT_VALID), 0);
    chk({nm, "_data"}, 64'(bus.OUT_DATA), 0);
    chk({nm, "_ovf"}, 64'(OVERFLOW), 0);
    chk({nm, "_count"}, 64'(ECHO_COUNT), 0);
    chk({nm, "_len"}, 64'(LAST_ECHO_LEN), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{len: 10, gap: 2,  exp_cnt: 16'd1, exp_len: 16'd10};
    tbl[1] = '{len: 10, gap: 10, exp_cnt: 16'd2, exp_len: 16'd10};
    tbl[2] = '{len: 1,  gap: 10, exp_cnt: 16'd3, exp_len: 16'd1};
    tbl[3] = '{len: 3,  gap: 10, exp_cnt: 16'd4, exp_len: 16'd3};

    bus.OUT_READY = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    RESET_N = 1'b1;
    bus.OUT_READY = 1'b1;

    // Echo table: words, counters and lengths per echo.
    for (int t = 0; t < 4; t++) begin
      for (int g = 0; g < tbl[t].gap; g++) tick();
      echo(tbl[t].len, tbl[t].len, 1'b0, AW'(16 * t));
      drain("tbl");
      chk("tbl_count", 64'(ECHO_COUNT), 64'(tbl[t].exp_cnt));
      chk("tbl_len", 64'(LAST_ECHO_LEN), 64'(tbl[t].exp_len));
    end

    // Single-cycle pulse: written one edge later, visible one edge after that.
    bus.OUT_READY = 1'b0;
    ACQ_EN = 1'b1; ADC_DATA = 12'h5A5;
    tick();
    ACQ_EN = 1'b0;
    tick();
    chk("lat_level", 64'(FIFO_LEVEL), 1);
    chk("lat_valid_early", 64'(bus.OUT_VALID), 0);
    tick();
    chk("lat_valid", 64'(bus.OUT_VALID), 1);
    chk("lat_word", 64'(bus.OUT_DATA), 64'(mk(1'b1, EW'(mdl_echo), 12'h5A5)));
    chk("lat_len", 64'(LAST_ECHO_LEN), 1);
    exp_q.push_back(mk(1'b1, EW'(mdl_echo), 12'h5A5));
    mdl_echo++;
    bus.OUT_READY = 1'b1;
    drain("lat");

    // Overflow: 12 samples into 8 entries with the consumer stalled.
    CLR = 1'b1; tick(); CLR = 1'b0;
    mdl_echo = 0;
    chk("clr_count", 64'(ECHO_COUNT), 0);
    chk("clr_len", 64'(LAST_ECHO_LEN), 0);
    bus.OUT_READY = 1'b0;
    echo(12, 8, 1'b0, 12'h100);
    tick();
    chk("ovf_level", 64'(FIFO_LEVEL), 8);
    chk("ovf_flag", 64'(OVERFLOW), 1);
    chk("ovf_count", 64'(ECHO_COUNT), 1);
    chk("ovf_len", 64'(LAST_ECHO_LEN), 12);
    bus.OUT_READY = 1'b1;
    drain("ovf");
    chk("ovf_sticky", 64'(OVERFLOW), 1);

    // CLR at sample 4 of a 10-sample echo: nothing from that echo survives.
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ACQ_EN = 1'b1; ADC_DATA = AW'(i); CLR = (i == 4);
      tick();
      if (i == 3) chk("clrmid_pre_level", 64'(FIFO_LEVEL), 3);
      if (i == 4) begin
        chk("clrmid_level", 64'(FIFO_LEVEL), 0);
        chk("clrmid_valid", 64'(bus.OUT_VALID), 0);
        chk("clrmid_ovf", 64'(OVERFLOW), 0);
      end
    end
    CLR = 1'b0;
    chk("clrmid_discard_level", 64'(FIFO_LEVEL), 0);
    ACQ_EN = 1'b0;
    tick();
    bus.OUT_READY = 1'b1;
    repeat (4) tick();
    chk("clrmid_nwords", 64'(rx_q.size() - rx_rd), 0);
    chk("clrmid_count", 64'(ECHO_COUNT), 0);
    mdl_echo = 0;
    echo(3, 3, 1'b0, 12'h0A0);
    drain("postclr");

    // Reset mid-echo, released while ACQ_EN is still high.
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ACQ_EN = 1'b1; ADC_DATA = AW'(12'h200 + i);
      tick();
    end
    #3 RESET_N = 1'b0;
    #1 chk_zero("rst_async");
    tick();
    tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ACQ_EN = 1'b1; ADC_DATA = AW'(12'h300 + i);
      tick();
    end
    ACQ_EN = 1'b0;
    tick();
    bus.OUT_READY = 1'b1;
    repeat (4) tick();
    chk("rstmid_level", 64'(FIFO_LEVEL), 0);
    chk("rstmid_nwords", 64'(rx_q.size() - rx_rd), 0);
    chk("rstmid_count", 64'(ECHO_COUNT), 0);
    mdl_echo = 0;
    rx_rd = rx_q.size();

    // Random backpressure over three echoes; order and tags must hold.
    rand_rdy = 1'b1;
    for (int e = 0; e < 3; e++) begin
      int k;
      repeat ($urandom_range(2, 6)) tick();
      echo($urandom_range(1, 6), 6, 1'b1, '0);
      k = 0;
      while (FIFO_LEVEL != 0 && k < 500) begin
        tick();
        k++;
      end
    end
    rand_rdy = 1'b0;
    bus.OUT_READY = 1'b1;
    drain("rand");
    chk("rand_count", 64'(ECHO_COUNT), 3);
    chk("rand_len", 64'(LAST_ECHO_LEN), 64'(mdl_len));
    chk("rand_ovf", 64'(OVERFLOW), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
